usb2_ep_arbiter: RTL and testbench

USB2_EP_ARBITER -- requirements
Module: usb2_ep_arbiter

---
 rtl/usb2_ep_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_usb2_ep_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep_arbiter.sv
// usb2_ep_arbiter
//   Routes the USB2 protocol engine's buffer handshake to one of three
//   endpoints, chosen by the most recent token.
//
//   Token path
//     tok_strobe/tok_ep/tok_pid  decoded token.
//                                EP0..EP2 select an endpoint.
//                                Higher numbers stall.
//     ep_stall                   one-cycle pulse for a nonexistent endpoint.
//   Protocol side
//     buf_in_commit / buf_in_commit_ack  OUT/SETUP payload handshake
//     buf_out_arm / buf_out_arm_ack      IN payload handshake
//     buf_in_ready, buf_out_q, buf_out_len, buf_out_hasdata
//                                        view of the selected endpoint.
//                                        These read 0 while idle.
//   Endpoint side (3 endpoints, packed vectors)
//     ep_commit/ep_commit_ack, ep_arm/ep_arm_ack  per-endpoint handshakes
//     ep_in_ready, ep_out_q, ep_out_len, ep_out_hasdata  endpoint status
//   Status
//     data_toggle  per-endpoint DATA0/DATA1 bit
//     err_timeout  sticky flag; set when an endpoint did not acknowledge
//                  within TIMEOUT cycles.
//   TIMEOUT must lie in 1..255 so that the 8-bit wait counter can reach it.
module usb2_ep_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        phy_clk,
  input  logic        reset_n,
  input  logic        tok_strobe,
  input  logic [3:0]  tok_ep,
  input  logic [3:0]  tok_pid,
  input  logic        buf_in_commit,
  output logic        buf_in_commit_ack,
  output logic        buf_in_ready,
  input  logic        buf_out_arm,
  output logic        buf_out_arm_ack,
  output logic [7:0]  buf_out_q,
  output logic [9:0]  buf_out_len,
  output logic        buf_out_hasdata,
  output logic        ep_stall,
  input  logic [2:0]  ep_in_ready,
  output logic [2:0]  ep_commit,
  input  logic [2:0]  ep_commit_ack,
  output logic [2:0]  ep_arm,
  input  logic [2:0]  ep_arm_ack,
  input  logic [23:0] ep_out_q,
  input  logic [29:0] ep_out_len,
  input  logic [2:0]  ep_out_hasdata,
  output logic [2:0]  data_toggle,
  output logic        err_timeout
);

  localparam logic [3:0] PID_SETUP   = 4'h2;
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ACTIVE      = 3'd1,
    ST_COMMIT_WAIT = 3'd2,
    ST_ARM_WAIT    = 3'd3,
    ST_RELEASE     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  toggle_q, toggle_d;
  logic        stall_q, stall_d;
  logic        err_q, err_d;

  logic [2:0]  sel_oh_s;
  logic        commit_ack_sel_s;
  logic        arm_ack_sel_s;
  logic        tok_valid_s;
  logic        tok_setup_ep0_s;
  logic [8:0]  cnt_next_s;
  logic        tmo_hit_s;

  // One-hot decode of an endpoint index; index 3 selects nothing.
  function automatic logic [2:0] ep_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign sel_oh_s         = ep_onehot(sel_q);
  // Masking with the one-hot select discards acks from unselected endpoints.
  assign commit_ack_sel_s = |(ep_commit_ack & sel_oh_s);
  assign arm_ack_sel_s    = |(ep_arm_ack & sel_oh_s);
  assign tok_valid_s      = (tok_ep <= 4'd2);
  // A SETUP to EP0 starts a control transfer; its data stage is DATA1.
  assign tok_setup_ep0_s  = (tok_pid == PID_SETUP) && (tok_ep == 4'd0);
  assign cnt_next_s       = {1'b0, cnt_q} + 9'd1;
  assign tmo_hit_s        = (cnt_next_s == TIMEOUT_LIM);

  // Next-state, select, wait counter, toggle and status computation.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    toggle_d = toggle_q;
    stall_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (tok_strobe) begin
          if (tok_valid_s) begin
            sel_d   = tok_ep[1:0];
            state_d = ST_ACTIVE;
            if (tok_setup_ep0_s) begin
              toggle_d[0] = 1'b1;
            end else begin
              toggle_d[0] = toggle_q[0];
            end
          end else begin
            stall_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (buf_in_commit) begin
          // Commit wins over a simultaneous arm.
          cnt_d   = 8'd0;
          state_d = ST_COMMIT_WAIT;
        end else if (buf_out_arm) begin
          cnt_d   = 8'd0;
          state_d = ST_ARM_WAIT;
        end else if (tok_strobe && tok_valid_s) begin
          // No transfer started yet: a fresh token re-targets the endpoint.
          sel_d = tok_ep[1:0];
          if (tok_setup_ep0_s) begin
            toggle_d[0] = 1'b1;
          end else begin
            toggle_d[0] = toggle_q[0];
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_COMMIT_WAIT: begin
        if (commit_ack_sel_s) begin
          toggle_d = toggle_q ^ sel_oh_s;
          state_d  = ST_RELEASE;
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_next_s[7:0];
        end
      end
      ST_ARM_WAIT: begin
        if (arm_ack_sel_s) begin
          toggle_d = toggle_q ^ sel_oh_s;
          state_d  = ST_RELEASE;
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_next_s[7:0];
        end
      end
      ST_RELEASE: begin
        // Wait for both sides to drop their handshake before taking a new token.
        if (!buf_in_commit && !buf_out_arm && !commit_ack_sel_s && !arm_ack_sel_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers with asynchronous active-low reset.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 8'd0;
      toggle_q <= 3'b000;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // The handshake strobes decode the state register directly.
  // A reset therefore drops them without waiting for a clock.
  assign ep_commit         = (state_q == ST_COMMIT_WAIT) ? sel_oh_s : 3'b000;
  assign ep_arm            = (state_q == ST_ARM_WAIT)    ? sel_oh_s : 3'b000;
  assign buf_in_commit_ack = (state_q == ST_COMMIT_WAIT) & commit_ack_sel_s;
  assign buf_out_arm_ack   = (state_q == ST_ARM_WAIT)    & arm_ack_sel_s;
  assign ep_stall          = stall_q;
  assign err_timeout       = err_q;
  assign data_toggle       = toggle_q;

  // Status mux: shows the selected endpoint outside IDLE, and zero while idle.
  always_comb begin
    buf_out_q       = 8'h00;
    buf_out_len     = 10'd0;
    buf_out_hasdata = 1'b0;
    buf_in_ready    = 1'b0;
    if (state_q != ST_IDLE) begin
      case (sel_q)
        2'd0: begin
          buf_out_q       = ep_out_q[7:0];
          buf_out_len     = ep_out_len[9:0];
          buf_out_hasdata = ep_out_hasdata[0];
          buf_in_ready    = ep_in_ready[0];
        end
        2'd1: begin
          buf_out_q       = ep_out_q[15:8];
          buf_out_len     = ep_out_len[19:10];
          buf_out_hasdata = ep_out_hasdata[1];
          buf_in_ready    = ep_in_ready[1];
        end
        2'd2: begin
          buf_out_q       = ep_out_q[23:16];
          buf_out_len     = ep_out_len[29:20];
          buf_out_hasdata = ep_out_hasdata[2];
          buf_in_ready    = ep_in_ready[2];
        end
        default: begin
          buf_out_q       = 8'h00;
          buf_out_len     = 10'd0;
          buf_out_hasdata = 1'b0;
          buf_in_ready    = 1'b0;
        end
      endcase
    end else begin
      buf_out_q       = 8'h00;
      buf_out_len     = 10'd0;
      buf_out_hasdata = 1'b0;
      buf_in_ready    = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb2_ep_arbiter.sv
// Testbench for usb2_ep_arbiter.
// It drives token and transfer transactions and predicts the outcomes
// from the arbiter rules.
// The reference model tracks the selected endpoint, the data toggles
// and the sticky timeout flag.
module tb_usb2_ep_arbiter;

  localparam int         TMO       = 255;
  localparam logic [3:0] PID_SETUP = 4'h2;
  localparam logic [3:0] PID_IN    = 4'h6;
  localparam logic [3:0] PID_OUT   = 4'hE;

  logic        phy_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tok_strobe = 1'b0;
  logic [3:0]  tok_ep = 4'd0;
  logic [3:0]  tok_pid = 4'd0;
  logic        buf_in_commit = 1'b0;
  logic        buf_in_commit_ack;
  logic        buf_in_ready;
  logic        buf_out_arm = 1'b0;
  logic        buf_out_arm_ack;
  logic [7:0]  buf_out_q;
  logic [9:0]  buf_out_len;
  logic        buf_out_hasdata;
  logic        ep_stall;
  logic [2:0]  ep_in_ready = 3'b111;
  logic [2:0]  ep_commit;
  logic [2:0]  ep_commit_ack = 3'b000;
  logic [2:0]  ep_arm;
  logic [2:0]  ep_arm_ack = 3'b000;
  logic [23:0] ep_out_q = 24'h010101;
  logic [29:0] ep_out_len = 30'h00100401;
  logic [2:0]  ep_out_hasdata = 3'b111;
  logic [2:0]  data_toggle;
  logic        err_timeout;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  logic [2:0] m_toggle = 3'b000;
  logic       m_err = 1'b0;
  int         m_sel = 0;

  usb2_ep_arbiter #(.TIMEOUT(TMO)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .tok_strobe(tok_strobe), .tok_ep(tok_ep), .tok_pid(tok_pid),
    .buf_in_commit(buf_in_commit), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_in_ready(buf_in_ready),
    .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .buf_out_q(buf_out_q), .buf_out_len(buf_out_len), .buf_out_hasdata(buf_out_hasdata),
    .ep_stall(ep_stall), .ep_in_ready(ep_in_ready),
    .ep_commit(ep_commit), .ep_commit_ack(ep_commit_ack),
    .ep_arm(ep_arm), .ep_arm_ack(ep_arm_ack),
    .ep_out_q(ep_out_q), .ep_out_len(ep_out_len), .ep_out_hasdata(ep_out_hasdata),
    .data_toggle(data_toggle), .err_timeout(err_timeout)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs expected while the arbiter sits idle (hasdata/ready inputs are all ones).
  task automatic check_idle(input string tag);
    chk({tag, "_hasdata"}, 32'(buf_out_hasdata), 32'd0);
    chk({tag, "_inready"}, 32'(buf_in_ready), 32'd0);
    chk({tag, "_qlen"}, 32'({buf_out_q, buf_out_len}), 32'd0);
    chk({tag, "_strobes"}, 32'({ep_commit, ep_arm}), 32'd0);
  endtask

  // Outputs expected once endpoint ep is selected.
  task automatic check_sel(input string tag, input int ep);
    chk({tag, "_q"}, 32'(buf_out_q), 32'((ep_out_q >> (8 * ep)) & 24'hFF));
    chk({tag, "_len"}, 32'(buf_out_len), 32'((ep_out_len >> (10 * ep)) & 30'h3FF));
    chk({tag, "_hasdata"}, 32'(buf_out_hasdata), 32'd1);
    chk({tag, "_inready"}, 32'(buf_in_ready), 32'd1);
  endtask

  task automatic send_token(input int ep, input logic [3:0] pid);
    @(negedge phy_clk);
    // every byte and length nonzero so that a zeroed mux is observable
    ep_out_q   = 24'($urandom) | 24'h010101;
    ep_out_len = 30'($urandom) | 30'h00100401;
    tok_strobe = 1'b1;
    tok_ep     = 4'(ep);
    tok_pid    = pid;
    #1;
    chk("stall_before_edge", 32'(ep_stall), 32'd0);
    @(negedge phy_clk);
    tok_strobe = 1'b0;
    #1;
    if (ep <= 2) begin
      m_sel = ep;
      if (pid == PID_SETUP && ep == 0) m_toggle[0] = 1'b1;
      chk("tok_nostall", 32'(ep_stall), 32'd0);
      check_sel("tok_sel", ep);
      chk("tok_toggle", 32'(data_toggle), 32'(m_toggle));
    end else begin
      chk("stall_pulse", 32'(ep_stall), 32'd1);
      check_idle("stall_idle");
      @(negedge phy_clk);
      #1;
      chk("stall_one_cycle", 32'(ep_stall), 32'd0);
      check_idle("stall_idle2");
    end
  endtask

  // kind: 1 = commit, 2 = arm, 3 = both (commit expected to win)
  task automatic do_xfer(input int kind, input int delay, input bit timeout);
    logic [2:0] oh;
    logic [2:0] spur;
    bit         is_commit;
    int         n_wait;
    oh        = 3'(1 << m_sel);
    spur      = ~oh;
    is_commit = (kind & 1) != 0;
    n_wait    = timeout ? TMO : delay;
    buf_in_commit = (kind & 1) != 0;
    buf_out_arm   = (kind & 2) != 0;
    for (int c = 0; c < n_wait; c++) begin
      @(negedge phy_clk);
      ep_commit_ack = spur;
      ep_arm_ack    = spur;
      #1;
      chk("wait_commit", 32'(ep_commit), is_commit ? 32'(oh) : 32'd0);
      chk("wait_arm", 32'(ep_arm), is_commit ? 32'd0 : 32'(oh));
      chk("wait_noack", 32'({buf_in_commit_ack, buf_out_arm_ack}), 32'd0);
      if (c == n_wait - 1) chk("wait_err", 32'(err_timeout), 32'(m_err));
    end
    if (!timeout) begin
      @(negedge phy_clk);
      if (is_commit) ep_commit_ack = spur | oh;
      else           ep_arm_ack    = spur | oh;
      #1;
      chk("ack_follow", 32'({buf_in_commit_ack, buf_out_arm_ack}),
          is_commit ? 32'd2 : 32'd1);
      m_toggle = m_toggle ^ oh;
    end else begin
      m_err = 1'b1;
    end
    @(negedge phy_clk);
    #1;
    chk("rel_strobes", 32'({ep_commit, ep_arm}), 32'd0);
    chk("rel_acks", 32'({buf_in_commit_ack, buf_out_arm_ack}), 32'd0);
    chk("rel_toggle", 32'(data_toggle), 32'(m_toggle));
    chk("rel_err", 32'(err_timeout), 32'(m_err));
    chk("rel_not_idle", 32'(buf_out_hasdata), 32'd1);
    if (!timeout) begin
      // protocol drops its request first; the endpoint ack is still up
      buf_in_commit = 1'b0;
      buf_out_arm   = 1'b0;
    end
    @(negedge phy_clk);
    #1;
    chk("rel_hold", 32'(buf_out_hasdata), 32'd1);
    buf_in_commit = 1'b0;
    buf_out_arm   = 1'b0;
    ep_commit_ack = 3'b000;
    ep_arm_ack    = 3'b000;
    @(negedge phy_clk);
    #1;
    check_idle("back_idle");
  endtask

  initial begin
    logic [3:0] pids [3];
    int ep, ep2, kind;
    pids[0] = PID_SETUP;
    pids[1] = PID_IN;
    pids[2] = PID_OUT;

    // reset state
    #2;
    chk("rst_toggle", 32'(data_toggle), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_stall", 32'(ep_stall), 32'd0);
    check_idle("rst");
    @(negedge phy_clk);
    @(negedge phy_clk);
    reset_n = 1'b1;

    // EP1 commit, ack after 3 cycles
    send_token(1, PID_OUT);
    do_xfer(1, 3, 1'b0);
    chk("ep1_toggle", 32'(data_toggle), 32'b010);

    // SETUP to EP0 forces DATA1, then a commit flips it back
    send_token(0, PID_SETUP);
    chk("setup_t0", 32'(data_toggle[0]), 32'd1);
    do_xfer(1, 1, 1'b0);
    chk("setup_after", 32'(data_toggle[0]), 32'd0);

    // nonexistent endpoint
    send_token(5, PID_IN);

    // commit and arm together on EP0 with spurious acks from EP1/EP2
    send_token(0, PID_OUT);
    do_xfer(3, 2, 1'b0);

    // EP2 arm timeout
    send_token(2, PID_IN);
    do_xfer(2, 0, 1'b1);
    chk("tmo_toggle2", 32'(data_toggle[2]), 32'd0);

    // token re-latch from ACTIVE
    send_token(0, PID_IN);
    send_token(2, PID_OUT);
    do_xfer(1, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      ep = $urandom_range(0, 4);
      send_token(ep, pids[$urandom_range(0, 2)]);
      if (ep <= 2) begin
        if ($urandom_range(0, 3) == 0) begin
          ep2 = $urandom_range(0, 2);
          send_token(ep2, pids[$urandom_range(0, 2)]);
        end
        kind = $urandom_range(1, 3);
        do_xfer(kind, $urandom_range(0, 6), $urandom_range(0, 19) == 0);
      end
    end

    // reset in the middle of a commit handshake
    send_token(1, PID_OUT);
    do_xfer(1, 0, 1'b0);
    send_token(1, PID_OUT);
    buf_in_commit = 1'b1;
    @(negedge phy_clk);
    @(negedge phy_clk);
    ep_commit_ack = 3'b010;
    #1;
    chk("pre_rst_commit", 32'(ep_commit), 32'b010);
    chk("pre_rst_ack", 32'(buf_in_commit_ack), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    m_toggle = 3'b000;
    m_err    = 1'b0;
    chk("async_commit", 32'(ep_commit), 32'd0);
    chk("async_ack", 32'(buf_in_commit_ack), 32'd0);
    chk("async_toggle", 32'(data_toggle), 32'd0);
    chk("async_err", 32'(err_timeout), 32'd0);
    chk("async_arm_stall", 32'({ep_arm, ep_stall}), 32'd0);
    buf_in_commit = 1'b0;
    ep_commit_ack = 3'b000;
    @(negedge phy_clk);
    reset_n = 1'b1;
    #1;
    check_idle("post_rst");

    send_token(2, PID_IN);
    do_xfer(2, 2, 1'b0);
    chk("post_rst_toggle", 32'(data_toggle), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
